mem_port_arbiter: RTL and testbench

- Shares one single-ported memory between the instruction-fetch requester (imem_*) and the data load/store requester (dmem_*).
- Sits between instruction_fetch / the load-store unit and the memory.
- Two-requester round-robin arbitration; the granted request is registered onto the memory port and held until the memory acknowledges.
- Each transaction is non-pipelined, with a maximum of one outstanding transaction.

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
//   arb_state_e : arbiter FSM states (IDLE, BUSY_I, BUSY_D)
//   grant_e     : which requester was served last (GRANT_I, GRANT_D)
//   BE_WIDTH    : byte-enable width for the default data width
//   BE_ALL_ONES : full-word byte enable, used for instruction fetches
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUSY_I,
      BUSY_D
   } arb_state_e;

   typedef enum logic {
      GRANT_I,
      GRANT_D
   } grant_e;

   localparam int unsigned MEM_ADDR_WIDTH_DEF = 32;
   localparam int unsigned MEM_DATA_WIDTH_DEF = 32;
   localparam int unsigned BE_WIDTH           = MEM_DATA_WIDTH_DEF / 8;
   localparam logic [BE_WIDTH-1:0] BE_ALL_ONES = '1;

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the instruction
// fetch requester (imem_*) and the load/store requester (dmem_*).
// Round-robin between the two; the granted request is registered onto the
// mem_* port and held until mem_ack_i. One transaction outstanding at a time.
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   imem_req_i/addr_i             fetch request (held until imem_ack_o)
//   imem_ack_o/rdata_o            fetch completion pulse and data
//   dmem_req_i/we_i/addr_i/
//   wdata_i/be_i                  load/store request (held until dmem_ack_o)
//   dmem_ack_o/rdata_o            load/store completion pulse and data
//   mem_req_o/we_o/addr_o/
//   wdata_o/be_o                  registered memory request
//   mem_ack_i/rdata_i             memory completion and read data
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned MEM_ADDR_WIDTH = MEM_ADDR_WIDTH_DEF,
   parameter int unsigned MEM_DATA_WIDTH = MEM_DATA_WIDTH_DEF
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        imem_req_i,
   input  logic [MEM_ADDR_WIDTH-1:0]   imem_addr_i,
   output logic                        imem_ack_o,
   output logic [MEM_DATA_WIDTH-1:0]   imem_rdata_o,
   input  logic                        dmem_req_i,
   input  logic                        dmem_we_i,
   input  logic [MEM_ADDR_WIDTH-1:0]   dmem_addr_i,
   input  logic [MEM_DATA_WIDTH-1:0]   dmem_wdata_i,
   input  logic [MEM_DATA_WIDTH/8-1:0] dmem_be_i,
   output logic                        dmem_ack_o,
   output logic [MEM_DATA_WIDTH-1:0]   dmem_rdata_o,
   output logic                        mem_req_o,
   output logic                        mem_we_o,
   output logic [MEM_ADDR_WIDTH-1:0]   mem_addr_o,
   output logic [MEM_DATA_WIDTH-1:0]   mem_wdata_o,
   output logic [MEM_DATA_WIDTH/8-1:0] mem_be_o,
   input  logic                        mem_ack_i,
   input  logic [MEM_DATA_WIDTH-1:0]   mem_rdata_i
);

   localparam int unsigned BE_W = MEM_DATA_WIDTH / 8;

   arb_state_e                state_q, state_d;
   grant_e                    last_grant_q, last_grant_d;
   logic                      mem_we_q, mem_we_d;
   logic [MEM_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [MEM_DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic [BE_W-1:0]           mem_be_q, mem_be_d;
   logic                      take_i, take_d;

   // Grant decision. A requester is only sampled in IDLE or at the ack edge
   // of the *other* side, so the same side can never be served twice without
   // passing through IDLE.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_be_d     = mem_be_q;
      take_i       = 1'b0;
      take_d       = 1'b0;

      unique case (state_q)
         IDLE: begin
            // Tie goes to whichever side was not served last.
            if (imem_req_i && (!dmem_req_i || (last_grant_q == GRANT_D))) begin
               take_i = 1'b1;
            end else if (dmem_req_i) begin
               take_d = 1'b1;
            end
         end
         BUSY_I: begin
            if (mem_ack_i) begin
               last_grant_d = GRANT_I;
               take_d       = dmem_req_i;
               state_d      = IDLE;
            end
         end
         BUSY_D: begin
            if (mem_ack_i) begin
               last_grant_d = GRANT_D;
               take_i       = imem_req_i;
               state_d      = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (take_i) begin
         state_d     = BUSY_I;
         mem_we_d    = 1'b0;
         mem_addr_d  = imem_addr_i;
         mem_wdata_d = '0;
         mem_be_d    = '1;
      end
      if (take_d) begin
         state_d     = BUSY_D;
         mem_we_d    = dmem_we_i;
         mem_addr_d  = dmem_addr_i;
         mem_wdata_d = dmem_wdata_i;
         mem_be_d    = dmem_be_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         last_grant_q <= GRANT_D;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_be_q     <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_be_q     <= mem_be_d;
      end
   end

   assign mem_req_o    = (state_q == BUSY_I) || (state_q == BUSY_D);
   assign mem_we_o     = mem_we_q;
   assign mem_addr_o   = mem_addr_q;
   assign mem_wdata_o  = mem_wdata_q;
   assign mem_be_o     = mem_be_q;

   // Response path is purely combinational; acks are steered by the state.
   assign imem_ack_o   = mem_ack_i && (state_q == BUSY_I);
   assign dmem_ack_o   = mem_ack_i && (state_q == BUSY_D);
   assign imem_rdata_o = mem_rdata_i;
   assign dmem_rdata_o = mem_rdata_i;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed stimulus pushes expected
// grants into a scoreboard queue; a negedge monitor pops and compares each
// new memory transaction, checks hold stability and the ack/rdata steering.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   localparam logic [31:0] RD_KEY = 32'hDEADBFEF;

   logic                clk_i = 1'b0;
   logic                rst_i;
   logic                imem_req_i;
   logic [31:0]         imem_addr_i;
   logic                imem_ack_o;
   logic [31:0]         imem_rdata_o;
   logic                dmem_req_i;
   logic                dmem_we_i;
   logic [31:0]         dmem_addr_i;
   logic [31:0]         dmem_wdata_i;
   logic [BE_WIDTH-1:0] dmem_be_i;
   logic                dmem_ack_o;
   logic [31:0]         dmem_rdata_o;
   logic                mem_req_o;
   logic                mem_we_o;
   logic [31:0]         mem_addr_o;
   logic [31:0]         mem_wdata_o;
   logic [BE_WIDTH-1:0] mem_be_o;
   logic                mem_ack_i;
   logic [31:0]         mem_rdata_i;

   mem_port_arbiter #(.MEM_ADDR_WIDTH(32), .MEM_DATA_WIDTH(32)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .imem_req_i(imem_req_i), .imem_addr_i(imem_addr_i),
      .imem_ack_o(imem_ack_o), .imem_rdata_o(imem_rdata_o),
      .dmem_req_i(dmem_req_i), .dmem_we_i(dmem_we_i), .dmem_addr_i(dmem_addr_i),
      .dmem_wdata_i(dmem_wdata_i), .dmem_be_i(dmem_be_i),
      .dmem_ack_o(dmem_ack_o), .dmem_rdata_o(dmem_rdata_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
      .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic                side;   // 0 = instruction, 1 = data
      logic                we;
      logic [31:0]         addr;
      logic [31:0]         wdata;
      logic [BE_WIDTH-1:0] be;
   } exp_t;

   exp_t exp_q[$];
   exp_t cur;
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_i(input logic [31:0] addr);
      exp_t e;
      e.side = 1'b0; e.we = 1'b0; e.addr = addr; e.wdata = '0; e.be = BE_ALL_ONES;
      exp_q.push_back(e);
   endtask

   task automatic push_d(input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [BE_WIDTH-1:0] be);
      exp_t e;
      e.side = 1'b1; e.we = we; e.addr = addr; e.wdata = wdata; e.be = be;
      exp_q.push_back(e);
   endtask

   // Memory model: acks after resp_lat BUSY cycles; rdata = addr ^ RD_KEY.
   int   resp_lat  = 1;
   int   resp_cnt  = 0;
   logic stray_ack = 1'b0;

   always @(posedge clk_i) begin
      #2;
      mem_rdata_i = mem_addr_o ^ RD_KEY;
      if (rst_i === 1'b1 || mem_req_o !== 1'b1) begin
         mem_ack_i = stray_ack;
         resp_cnt  = 0;
      end else if (resp_cnt == resp_lat) begin
         mem_ack_i = 1'b1;
         resp_cnt  = 0;
      end else begin
         mem_ack_i = 1'b0;
         resp_cnt++;
      end
   end

   // Scoreboard monitor.
   logic prev_req = 1'b0;
   logic prev_ack = 1'b0;

   always @(negedge clk_i) begin
      if (rst_i !== 1'b1 && mem_req_o === 1'b1) begin
         if (!prev_req || prev_ack) begin
            if (exp_q.size() == 0) begin
               check("unexpected_grant", {mem_we_o, mem_addr_o}, 128'h0);
               cur.side = 1'b0; cur.we = mem_we_o; cur.addr = mem_addr_o;
               cur.wdata = mem_wdata_o; cur.be = mem_be_o;
            end else begin
               cur = exp_q.pop_front();
               check("grant", {mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o},
                     {cur.we, cur.addr, cur.wdata, cur.be});
            end
         end else begin
            check("hold", {mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o},
                  {cur.we, cur.addr, cur.wdata, cur.be});
         end
         if (mem_ack_i === 1'b1) begin
            check("ack_steer", {imem_ack_o, dmem_ack_o}, cur.side ? 2'b01 : 2'b10);
            check("rdata", {imem_rdata_o, dmem_rdata_o},
                  {cur.addr ^ RD_KEY, cur.addr ^ RD_KEY});
         end
      end else if (mem_ack_i === 1'b1) begin
         check("idle_ack", {imem_ack_o, dmem_ack_o}, 2'b00);
      end
      prev_req = (mem_req_o === 1'b1);
      prev_ack = (mem_req_o === 1'b1) && (mem_ack_i === 1'b1);
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      tick();
      tick();
      rst_i = 1'b0;
   endtask

   // Waits (bounded) for the requested side's ack, then steps past its edge.
   task automatic wait_ack(input logic side, input string name);
      int  n;
      bit  seen;
      n = 0; seen = 0;
      while (!seen && n < 40) begin
         @(negedge clk_i);
         seen = side ? (dmem_ack_o === 1'b1) : (imem_ack_o === 1'b1);
         n++;
      end
      if (!seen) check(name, 128'h0, 128'h1);
      tick();
   endtask

   initial begin
      int ni, nd, gaps, budget;
      bit started;
      rst_i = 1'b1; imem_req_i = 1'b0; imem_addr_i = '0;
      dmem_req_i = 1'b0; dmem_we_i = 1'b0; dmem_addr_i = '0;
      dmem_wdata_i = '0; dmem_be_i = '0;
      mem_ack_i = 1'b0; mem_rdata_i = '0;

      // Reset state.
      do_reset();
      check("reset_state", {mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o}, 128'h0);

      // Fetch only, ack in the second BUSY cycle.
      resp_lat = 1;
      imem_req_i = 1'b1; imem_addr_i = 32'h100;
      push_i(32'h100);
      tick();
      check("fetch_latency", {mem_req_o, mem_addr_o, mem_we_o, mem_be_o},
            {1'b1, 32'h100, 1'b0, 4'hF});
      @(negedge clk_i);
      @(negedge clk_i);
      check("fetch_ack", {imem_ack_o, dmem_ack_o, imem_rdata_o}, {2'b10, 32'hDEADBEEF});
      tick();
      imem_req_i = 1'b0;
      check("fetch_idle", {31'h0, mem_req_o}, 128'h0);

      // Simultaneous first requests after reset: I first, D back-to-back.
      do_reset();
      imem_req_i = 1'b1; imem_addr_i = 32'h10;
      dmem_req_i = 1'b1; dmem_we_i = 1'b1; dmem_addr_i = 32'h2000;
      dmem_wdata_i = 32'h55AA55AA; dmem_be_i = 4'h3;
      push_i(32'h10);
      push_d(1'b1, 32'h2000, 32'h55AA55AA, 4'h3);
      wait_ack(1'b0, "tie_i_timeout");
      imem_req_i = 1'b0;
      check("tie_no_gap", {mem_req_o, mem_addr_o, mem_we_o, mem_be_o},
            {1'b1, 32'h2000, 1'b1, 4'h3});
      wait_ack(1'b1, "tie_d_timeout");
      dmem_req_i = 1'b0; dmem_we_i = 1'b0;

      // Continuous requests from both sides: strict alternation, no gaps.
      resp_lat = 1;
      imem_req_i = 1'b1; imem_addr_i = 32'h1000;
      dmem_req_i = 1'b1; dmem_we_i = 1'b0; dmem_addr_i = 32'h3000;
      dmem_wdata_i = 32'h11110000; dmem_be_i = 4'hF;
      push_i(32'h1000); push_d(1'b0, 32'h3000, 32'h11110000, 4'hF);
      push_i(32'h1004); push_d(1'b0, 32'h3010, 32'h11110001, 4'hF);
      push_i(32'h1008); push_d(1'b0, 32'h3020, 32'h11110002, 4'hF);
      ni = 0; nd = 0; gaps = 0; started = 0; budget = 0;
      while (ni + nd < 6 && budget < 100) begin
         @(negedge clk_i);
         budget++;
         if (mem_req_o === 1'b1) started = 1;
         else if (started) gaps++;
         if (imem_ack_o === 1'b1) begin
            tick();
            ni++;
            if (ni < 3) imem_addr_i = 32'h1000 + 32'(ni * 4);
            else imem_req_i = 1'b0;
         end else if (dmem_ack_o === 1'b1) begin
            tick();
            nd++;
            if (nd < 3) begin
               dmem_addr_i  = 32'h3000 + 32'(nd * 16);
               dmem_wdata_i = 32'h11110000 + 32'(nd);
            end else dmem_req_i = 1'b0;
         end
      end
      check("alt_count", {ni[7:0], nd[7:0]}, {8'd3, 8'd3});
      check("alt_gaps", 128'(gaps), 128'h0);

      // Stray ack in IDLE.
      tick();
      stray_ack = 1'b1;
      tick();
      stray_ack = 1'b0;
      tick();
      check("stray_idle", {imem_ack_o, dmem_ack_o, mem_req_o}, 3'b000);

      // Reset in the middle of a data transaction.
      resp_lat = 10;
      dmem_req_i = 1'b1; dmem_we_i = 1'b1; dmem_addr_i = 32'h500;
      dmem_wdata_i = 32'hCAFEF00D; dmem_be_i = 4'hC;
      push_d(1'b1, 32'h500, 32'hCAFEF00D, 4'hC);
      tick();
      check("busy_d_entered", {mem_req_o, mem_addr_o}, {1'b1, 32'h500});
      tick();
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      dmem_req_i = 1'b0; dmem_we_i = 1'b0;
      check("abort_req_low", {31'h0, mem_req_o}, 128'h0);
      stray_ack = 1'b1;
      @(negedge clk_i);
      check("abort_no_ack", {imem_ack_o, dmem_ack_o}, 2'b00);
      tick();
      stray_ack = 1'b0;
      resp_lat = 1;
      imem_req_i = 1'b1; imem_addr_i = 32'h20;
      dmem_req_i = 1'b1; dmem_addr_i = 32'h600; dmem_wdata_i = 32'h0; dmem_be_i = 4'hF;
      push_i(32'h20);
      push_d(1'b0, 32'h600, 32'h0, 4'hF);
      tick();
      check("post_reset_i_first", {mem_req_o, mem_addr_o}, {1'b1, 32'h20});
      wait_ack(1'b0, "post_reset_i_timeout");
      imem_req_i = 1'b0;
      wait_ack(1'b1, "post_reset_d_timeout");
      dmem_req_i = 1'b0;

      // Requester inputs changing while BUSY_D must not reach mem_*.
      resp_lat = 3;
      dmem_req_i = 1'b1; dmem_we_i = 1'b0; dmem_addr_i = 32'h40;
      dmem_wdata_i = 32'h0; dmem_be_i = 4'hF;
      push_d(1'b0, 32'h40, 32'h0, 4'hF);
      tick();
      dmem_addr_i = 32'h80; dmem_wdata_i = 32'h12345678; dmem_be_i = 4'h1; dmem_we_i = 1'b1;
      tick();
      check("stable_addr", {mem_addr_o, mem_wdata_o, mem_be_o, mem_we_o},
            {32'h40, 32'h0, 4'hF, 1'b0});
      wait_ack(1'b1, "stable_timeout");
      dmem_req_i = 1'b0; dmem_we_i = 1'b0;
      tick();

      check("queue_drained", 128'(exp_q.size()), 128'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
